// File: rtl/rd_port_arbiter.sv
// rtl/rd_port_arbiter.sv - round-robin sharing of one read AR/R channel with in-order R steering
module rd_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   s_arid_i,
  input  logic [NUM_PORTS-1:0]                 s_arvalid_i,
  output logic [NUM_PORTS-1:0]                 s_arready_o,
  output logic [DATA_WIDTH-1:0]                s_rdata_o,
  output logic [ID_WIDTH-1:0]                  s_rid_o,
  output logic [NUM_PORTS-1:0]                 s_rvalid_o,
  input  logic [NUM_PORTS-1:0]                 s_rready_i,
  output logic [ID_WIDTH-1:0]                  m_arid_o,
  output logic                                 m_arvalid_o,
  input  logic                                 m_arready_i,
  input  logic [DATA_WIDTH-1:0]                m_rdata_i,
  input  logic [ID_WIDTH-1:0]                  m_rid_i,
  input  logic                                 m_rvalid_i,
  output logic                                 m_rready_o,
  output logic [$clog2(DEPTH):0]               outstanding_o,
  output logic                                 err_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    ISSUE     = 1'b1;
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [PW:0]   NP        = (PW + 1)'(NUM_PORTS);

  logic [0:0]    state_q,  state_d;
  logic [PW-1:0] grant_q,  grant_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          err_q,    err_d;

  // Order FIFO: which port each accepted AR came from, and the ID it carried.
  logic [PW-1:0]       fifo_port_q [DEPTH];
  logic [ID_WIDTH-1:0] fifo_id_q   [DEPTH];

  logic [NUM_PORTS-1:0] req_rot;
  logic [PW-1:0]        pick_off;
  logic [PW:0]          pick_sum;
  logic [PW-1:0]        pick_port;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [PW-1:0]        head_port;
  logic [ID_WIDTH-1:0]  head_id;

  // count_q tracks FIFO occupancy exactly; since DEPTH is a power of two, bit AW means full.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = count_q[AW];
  assign head_port  = fifo_port_q[rd_ptr_q];
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign push       = (state_q == ISSUE) && m_arready_i;
  assign pop        = m_rvalid_i && m_rready_o;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    req_rot  = NUM_PORTS'({s_arvalid_i, s_arvalid_i} >> rr_ptr_q);
    pick_off = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = PW'(i);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NP) pick_sum = pick_sum - NP;
    pick_port = pick_sum[PW-1:0];
  end

  // AR state machine plus FIFO pointer, occupancy and error next-state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if ((|s_arvalid_i) && !fifo_full) begin
          grant_d = pick_port;
          state_d = ISSUE;
        end
      end
      default: begin
        if (m_arready_i) begin
          rr_ptr_d = (grant_q == LAST_PORT) ? '0 : grant_q + PW'(1);
          state_d  = IDLE;
        end
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A beat with nothing outstanding, or a popped beat whose ID disagrees with the head.
    if ((m_rvalid_i && fifo_empty) || (pop && (m_rid_i != head_id))) err_d = 1'b1;
  end

  // Control registers; reset aborts any issue in progress and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_port_q[wr_ptr_q] <= grant_q;
      fifo_id_q[wr_ptr_q]   <= s_arid_i[grant_q];
    end
  end

  // AR outputs: only the granted port sees ready, and only while issuing.
  always_comb begin
    s_arready_o = '0;
    m_arvalid_o = 1'b0;
    m_arid_o    = '0;
    if (state_q == ISSUE) begin
      m_arvalid_o          = 1'b1;
      m_arid_o             = s_arid_i[grant_q];
      s_arready_o[grant_q] = m_arready_i;
    end
  end

  // R steering: the beat belongs to the port at the FIFO head; nothing is accepted when empty.
  always_comb begin
    s_rvalid_o = '0;
    m_rready_o = 1'b0;
    if (!fifo_empty) begin
      s_rvalid_o[head_port] = m_rvalid_i;
      m_rready_o            = s_rready_i[head_port];
    end
  end

  assign s_rdata_o     = m_rdata_i;
  assign s_rid_o       = m_rid_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// tb/tb_rd_port_arbiter.sv - scoreboard bench for rd_port_arbiter
module tb_rd_port_arbiter;

  typedef struct packed {
    logic [1:0] port;
    logic [3:0] id;
  } ar_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic [3:0] id;
  } r_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][3:0] s_arid;
  logic [3:0]      s_arvalid;
  logic [3:0]      s_arready;
  logic [7:0]      s_rdata;
  logic [3:0]      s_rid;
  logic [3:0]      s_rvalid;
  logic [3:0]      s_rready;
  logic [3:0]      m_arid;
  logic            m_arvalid;
  logic            m_arready;
  logic [7:0]      m_rdata;
  logic [3:0]      m_rid;
  logic            m_rvalid;
  logic            m_rready;
  logic [3:0]      outstanding;
  logic            err;

  int n_pass  = 0;
  int n_total = 0;

  ar_t exp_ar[$];
  r_t  exp_r[$];

  always #5 clk = ~clk;

  rd_port_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(8), .ID_WIDTH(4), .DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid_i(s_arid), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rid_o(s_rid), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_arid_o(m_arid), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rid_i(m_rid), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .outstanding_o(outstanding), .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed AR or R handshake is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", {28'd0, m_arid}, 32'hFFFF_FFFF);
        end else begin
          ar_t e;
          logic [3:0] onehot;
          e = exp_ar.pop_front();
          onehot = 4'b0001 << e.port;
          chk("ar_grant", {28'd0, s_arready}, {28'd0, onehot});
          chk("ar_id", {28'd0, m_arid}, {28'd0, e.id});
        end
      end
      if (m_rvalid && m_rready) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", {24'd0, m_rdata}, 32'hFFFF_FFFF);
        end else begin
          r_t e;
          logic [3:0] onehot;
          e = exp_r.pop_front();
          onehot = 4'b0001 << e.port;
          chk("r_route", {28'd0, s_rvalid}, {28'd0, onehot});
          chk("r_data", {24'd0, s_rdata}, {24'd0, e.data});
          chk("r_id", {28'd0, s_rid}, {28'd0, e.id});
        end
      end
    end
  end

  task automatic ar_req(input logic [1:0] p, input logic [3:0] id);
    logic got;
    exp_ar.push_back('{port: p, id: id});
    s_arid[p]    = id;
    s_arvalid[p] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (m_arvalid && s_arready[p]) got = 1'b1;
    end
    @(posedge clk);
    #1;
    s_arvalid[p] = 1'b0;
    chk("ar_handshake_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic r_beat(input logic [1:0] p, input logic [7:0] d, input logic [3:0] id);
    logic got;
    exp_r.push_back('{port: p, data: d, id: id});
    m_rdata  = d;
    m_rid    = id;
    m_rvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (m_rready) got = 1'b1;
    end
    @(posedge clk);
    #1;
    m_rvalid = 1'b0;
    chk("r_handshake_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    s_arid    = '0;
    s_arvalid = '0;
    s_rready  = 4'b1111;
    m_arready = 1'b1;
    m_rdata   = '0;
    m_rid     = '0;
    m_rvalid  = 1'b0;
    #1;
    chk("reset_m_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("reset_m_arid", {28'd0, m_arid}, 32'd0);
    chk("reset_s_arready", {28'd0, s_arready}, 32'd0);
    chk("reset_s_rvalid", {28'd0, s_rvalid}, 32'd0);
    chk("reset_m_rready", {31'd0, m_rready}, 32'd0);
    chk("reset_outstanding", {28'd0, outstanding}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read from port 2, ID 5.
    exp_ar.push_back('{port: 2'd2, id: 4'd5});
    s_arid[2] = 4'd5;
    s_arvalid[2] = 1'b1;
    tick();
    chk("t1_arvalid", {31'd0, m_arvalid}, 32'd1);
    chk("t1_arid", {28'd0, m_arid}, 32'd5);
    chk("t1_arready", {28'd0, s_arready}, 32'b0100);
    tick();
    s_arvalid[2] = 1'b0;
    chk("t1_outstanding_1", {28'd0, outstanding}, 32'd1);
    exp_r.push_back('{port: 2'd2, data: 8'hA5, id: 4'd5});
    m_rid = 4'd5;
    m_rdata = 8'hA5;
    m_rvalid = 1'b1;
    #1;
    chk("t1_rvalid", {28'd0, s_rvalid}, 32'b0100);
    chk("t1_rdata", {24'd0, s_rdata}, 32'hA5);
    tick();
    m_rvalid = 1'b0;
    chk("t1_outstanding_0", {28'd0, outstanding}, 32'd0);

    // Ports 0 and 3 continuously from reset, then port 1 joins.
    do_reset();
    s_arid[0] = 4'd1;
    s_arid[3] = 4'd2;
    s_arid[1] = 4'd3;
    exp_ar.push_back('{port: 2'd0, id: 4'd1});
    exp_ar.push_back('{port: 2'd3, id: 4'd2});
    exp_ar.push_back('{port: 2'd0, id: 4'd1});
    exp_ar.push_back('{port: 2'd3, id: 4'd2});
    s_arvalid = 4'b1001;
    repeat (8) tick();
    s_arvalid = 4'b0000;
    chk("t2_outstanding_4", {28'd0, outstanding}, 32'd4);
    r_beat(2'd0, 8'h10, 4'd1);
    r_beat(2'd3, 8'h13, 4'd2);
    r_beat(2'd0, 8'h20, 4'd1);
    r_beat(2'd3, 8'h23, 4'd2);
    for (int k = 0; k < 2; k++) begin
      exp_ar.push_back('{port: 2'd0, id: 4'd1});
      exp_ar.push_back('{port: 2'd1, id: 4'd3});
      exp_ar.push_back('{port: 2'd3, id: 4'd2});
    end
    s_arvalid = 4'b1011;
    repeat (12) tick();
    s_arvalid = 4'b0000;
    chk("t2_outstanding_6", {28'd0, outstanding}, 32'd6);
    r_beat(2'd0, 8'h30, 4'd1);
    r_beat(2'd1, 8'h31, 4'd3);
    r_beat(2'd3, 8'h33, 4'd2);
    r_beat(2'd0, 8'h40, 4'd1);
    r_beat(2'd1, 8'h41, 4'd3);
    r_beat(2'd3, 8'h43, 4'd2);

    // Fill to DEPTH with R held off, then one pop lets the next grant through.
    do_reset();
    s_arid[1] = 4'd7;
    for (int k = 0; k < 9; k++) exp_ar.push_back('{port: 2'd1, id: 4'd7});
    s_arvalid = 4'b0010;
    repeat (16) tick();
    chk("t3_outstanding_full", {28'd0, outstanding}, 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stalled_arvalid", {31'd0, m_arvalid}, 32'd0);
    end
    exp_r.push_back('{port: 2'd1, data: 8'h70, id: 4'd7});
    m_rid = 4'd7;
    m_rdata = 8'h70;
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("t3_outstanding_7", {28'd0, outstanding}, 32'd7);
    chk("t3_idle_after_pop", {31'd0, m_arvalid}, 32'd0);
    tick();
    chk("t3_resumed_arvalid", {31'd0, m_arvalid}, 32'd1);
    chk("t3_resumed_arready", {28'd0, s_arready}, 32'b0010);
    tick();
    s_arvalid = 4'b0000;
    chk("t3_outstanding_refull", {28'd0, outstanding}, 32'd8);
    for (int k = 0; k < 8; k++) r_beat(2'd1, 8'h71 + 8'(k), 4'd7);

    // Reads from ports 1,2,1; port 2 back-pressures its beat for 4 cycles.
    ar_req(2'd1, 4'd1);
    ar_req(2'd2, 4'd2);
    ar_req(2'd1, 4'd3);
    r_beat(2'd1, 8'h11, 4'd1);
    exp_r.push_back('{port: 2'd2, data: 8'h22, id: 4'd2});
    s_rready = 4'b1011;
    m_rid = 4'd2;
    m_rdata = 8'h22;
    m_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_stall_rready", {31'd0, m_rready}, 32'd0);
      chk("t4_stall_rvalid", {28'd0, s_rvalid}, 32'b0100);
      tick();
    end
    s_rready = 4'b1111;
    #1;
    chk("t4_release_rready", {31'd0, m_rready}, 32'd1);
    tick();
    m_rvalid = 1'b0;
    r_beat(2'd1, 8'h33, 4'd3);
    chk("t4_outstanding_0", {28'd0, outstanding}, 32'd0);

    // R beat with nothing outstanding is sticky-flagged.
    do_reset();
    m_rid = 4'd0;
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("t5_err_empty", {31'd0, err}, 32'd1);
    ar_req(2'd0, 4'd4);
    r_beat(2'd0, 8'h44, 4'd4);
    chk("t5_err_sticky", {31'd0, err}, 32'd1);

    // ID mismatch at the head: still routed and popped, and flagged.
    do_reset();
    ar_req(2'd2, 4'd3);
    r_beat(2'd2, 8'h5A, 4'd4);
    chk("t5_err_mismatch", {31'd0, err}, 32'd1);
    chk("t5_mismatch_popped", {28'd0, outstanding}, 32'd0);

    // Reset during ISSUE with 3 reads outstanding.
    do_reset();
    ar_req(2'd0, 4'd1);
    ar_req(2'd0, 4'd2);
    ar_req(2'd0, 4'd3);
    chk("t6_outstanding_3", {28'd0, outstanding}, 32'd3);
    m_arready = 1'b0;
    s_arid[1] = 4'd6;
    s_arvalid[1] = 1'b1;
    tick();
    chk("t6_in_issue", {31'd0, m_arvalid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("t6_async_outstanding", {28'd0, outstanding}, 32'd0);
    chk("t6_async_arready", {28'd0, s_arready}, 32'd0);
    s_arvalid = 4'b0000;
    tick();
    rst_n = 1'b1;
    m_arready = 1'b1;
    tick();
    ar_req(2'd0, 4'd9);
    chk("t6_outstanding_after", {28'd0, outstanding}, 32'd1);
    r_beat(2'd0, 8'h99, 4'd9);
    chk("t6_err_clear", {31'd0, err}, 32'd0);

    repeat (3) tick();
    chk("ar_queue_drained", exp_ar.size(), 32'd0);
    chk("r_queue_drained", exp_r.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
